// File: rtl/maze_pkg.sv
// Shared definitions for the maze loader and the maze controller.
//   MAZE_ROWS / MAZE_COLS : default maze geometry (rows = memory depth,
//                           cols = row word width, bit 1 = wall)
//   maze_state_e          : loader FSM state encoding
package maze_pkg;

    localparam int MAZE_ROWS = 16;
    localparam int MAZE_COLS = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } maze_state_e;

endpackage

// File: rtl/maze_loader_if.sv
// Bus bundle between a row source (master) and the maze loader (slave).
//   load_start, din_valid, din [, din_par] : master -> loader
//   din_ready, mem_we, mem_addr, mem_wdata,
//   busy, load_done, load_err              : loader -> master / memory
// Optional macro MAZE_PARITY_EN adds din_par (even parity over din).
interface maze_loader_if #(
    parameter int ROWS = maze_pkg::MAZE_ROWS,
    parameter int COLS = maze_pkg::MAZE_COLS
) ();
    localparam int AW = $clog2(ROWS);

    logic            load_start;
    logic            din_valid;
    logic [COLS-1:0] din;
`ifdef MAZE_PARITY_EN
    logic            din_par;
`endif
    logic            din_ready;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [COLS-1:0] mem_wdata;
    logic            busy;
    logic            load_done;
    logic            load_err;

    modport slave (
        input  load_start, din_valid, din,
`ifdef MAZE_PARITY_EN
        input  din_par,
`endif
        output din_ready, mem_we, mem_addr, mem_wdata, busy, load_done, load_err
    );

    modport master (
        output load_start, din_valid, din,
`ifdef MAZE_PARITY_EN
        output din_par,
`endif
        input  din_ready, mem_we, mem_addr, mem_wdata, busy, load_done, load_err
    );
endinterface

// File: rtl/row_parity.sv
// Even-parity check of one maze row.
//   din     : row word
//   din_par : parity bit sent alongside the row
//   par_err : high when din and din_par together have odd parity
// Only instantiated when MAZE_PARITY_EN is defined.
module row_parity #(
    parameter int COLS = 16
) (
    input  logic [COLS-1:0] din,
    input  logic            din_par,
    output logic            par_err
);
    assign par_err = ^{din, din_par};
endmodule

// File: rtl/maze_loader.sv
// Streams ROWS row words into the maze memory and validates the maze.
//   clk      : single clock, rising edge
//   rst      : asynchronous, active-low reset
//   bus      : maze_loader_if.slave (handshake in, memory write port out,
//              busy / load_done / load_err status)
// Optional macro MAZE_PARITY_EN: per-row even parity; a bad row is still
// written but forces the load to end in ERR.
//
// state | meaning
// IDLE  | waiting for load_start after reset
// LOAD  | accepting rows, din_ready high
// CHECK | one cycle: evaluate start/exit cells (and parity flag)
// DONE  | maze valid, load_done held
// ERR   | load rejected, load_err held
module maze_loader
    import maze_pkg::*;
#(
    parameter int ROWS = MAZE_ROWS,
    parameter int COLS = MAZE_COLS
) (
    input  logic          clk,
    input  logic          rst,
    maze_loader_if.slave  bus
);
    localparam int            AW       = $clog2(ROWS);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    maze_state_e     state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [COLS-1:0] wdata_q, wdata_d;
    logic            start_wall_q, start_wall_d;
    logic            exit_wall_q, exit_wall_d;
    logic            xfer;
    logic            par_flag;

    // load_start wins over din_valid, so an abort cycle never writes.
    assign xfer = (state_q == LOAD) && bus.din_valid && !bus.load_start;

`ifdef MAZE_PARITY_EN
    logic par_err;
    logic par_flag_q, par_flag_d;

    row_parity #(.COLS(COLS)) u_row_parity (
        .din     (bus.din),
        .din_par (bus.din_par),
        .par_err (par_err)
    );

    always_comb begin
        par_flag_d = par_flag_q;
        if (bus.load_start) begin
            par_flag_d = 1'b0;
        end else if (xfer && par_err) begin
            par_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_flag_q <= 1'b0;
        end else begin
            par_flag_q <= par_flag_d;
        end
    end

    assign par_flag = par_flag_q;
`else
    assign par_flag = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        start_wall_d = start_wall_q;
        exit_wall_d  = exit_wall_q;

        if (bus.load_start) begin
            state_d = LOAD;
            row_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (xfer) begin
                        we_d    = 1'b1;
                        addr_d  = row_q;
                        wdata_d = bus.din;
                        if (row_q == '0) begin
                            start_wall_d = bus.din[0];
                        end
                        // Counter parks on the last row; no further transfer
                        // can happen because LOAD is left here.
                        if (row_q == LAST_ROW) begin
                            exit_wall_d = bus.din[COLS-1];
                            state_d     = CHECK;
                        end else begin
                            row_d = row_q + AW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (start_wall_q || exit_wall_q || par_flag) begin
                        state_d = ERR;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            start_wall_q <= 1'b0;
            exit_wall_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            start_wall_q <= start_wall_d;
            exit_wall_q  <= exit_wall_d;
        end
    end

    assign bus.din_ready = (state_q == LOAD);
    assign bus.busy      = (state_q == LOAD) || (state_q == CHECK);
    assign bus.load_done = (state_q == DONE);
    assign bus.load_err  = (state_q == ERR);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_maze_loader.sv
// Testbench for maze_loader (16 x 16 maze). Directed table vectors for
// single-cycle behaviour plus hand-written multi-cycle load sequences.
module tb_maze_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bad_par = 1'b0;

    always #5 clk = ~clk;

    maze_loader_if #(.ROWS(16), .COLS(16)) bus ();

    maze_loader #(.ROWS(16), .COLS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MAZE_PARITY_EN
    assign bus.din_par = (^bus.din) ^ bad_par;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  wr_addr [$];
    logic [15:0] wr_data [$];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
        end
    end

    typedef struct {
        logic        ls;
        logic        dv;
        logic [15:0] d;
        logic        rdy;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wd;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl [8];

    logic [15:0] std_rows [16];
    logic [15:0] rows     [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic we,
                           input logic [3:0] addr, input logic [15:0] wd,
                           input logic busy, input logic done, input logic err);
        chk({tag, "_rdy"},   32'(bus.din_ready), 32'(rdy));
        chk({tag, "_we"},    32'(bus.mem_we),    32'(we));
        chk({tag, "_addr"},  32'(bus.mem_addr),  32'(addr));
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(wd));
        chk({tag, "_busy"},  32'(bus.busy),      32'(busy));
        chk({tag, "_done"},  32'(bus.load_done), 32'(done));
        chk({tag, "_err"},   32'(bus.load_err),  32'(err));
    endtask

    task automatic do_reset();
        bus.load_start = 1'b0;
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bad_par        = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_row(input logic [15:0] d);
        bus.din_valid = 1'b1;
        bus.din       = d;
        step();
        bus.din_valid = 1'b0;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
    endtask

    // Counts cycles until DONE or ERR, starting from n_in.
    task automatic wait_end(input string tag, input int n_in, output int n_out);
        n_out = n_in;
        while (!(bus.load_done || bus.load_err) && n_out < 60) begin
            step();
            n_out++;
        end
        if (n_out >= 60) begin
            chk({tag, "_timeout"}, 32'(n_out), 32'd0);
        end
    endtask

    task automatic chk_log(input string tag, input logic [15:0] exp_rows [16]);
        chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(exp_rows[i]));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        std_rows[0]  = 16'hFFFE;
        for (int i = 1; i < 15; i++) std_rows[i] = 16'h0000;
        std_rows[15] = 16'h7FFF;

        //            ls    dv    din        rdy   we    addr  wdata      busy  done  err
        tbl[0] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 16'hBBBB, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b1, 4'd0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 4'd0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 16'h0F0E, 1'b1, 1'b1, 4'd0, 16'h0F0E, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0F0E, 1'b1, 1'b0, 1'b0};

        bus.load_start = 1'b0;
        bus.din_valid  = 1'b1;
        bus.din        = 16'hFFFF;
        rst = 1'b0;
        #12;
        chk_all("reset", 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Single-cycle table: IDLE ignore, start priority, write latency, gap, abort.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.load_start = tbl[i].ls;
            bus.din_valid  = tbl[i].dv;
            bus.din        = tbl[i].d;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].addr,
                    tbl[i].wd, tbl[i].busy, tbl[i].done, tbl[i].err);
        end
        bus.load_start = 1'b0;
        bus.din_valid  = 1'b0;

        // Normal load, back-to-back rows.
        do_reset();
        start_load();
        for (int i = 0; i < 16; i++) send_row(std_rows[i]);
        chk_all("check", 1'b0, 1'b1, 4'd15, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        wait_end("normal", 16, n);
        chk("normal_done_edges", 32'(n), 32'd17);
        chk_all("done", 1'b0, 1'b0, 4'd15, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        chk_log("normal", std_rows);
        send_row(16'h1234);
        chk_all("done_ignore", 1'b0, 1'b0, 4'd15, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        chk("done_ignore_nwrites", 32'(wr_addr.size()), 32'd16);

        // Blocked start cell.
        rows = std_rows;
        rows[0] = 16'h0001;
        wr_addr.delete();
        wr_data.delete();
        start_load();
        chk("blk_start_done_cleared", 32'(bus.load_done), 32'd0);
        chk("blk_start_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 16; i++) send_row(rows[i]);
        wait_end("blk_start", 16, n);
        chk("blk_start_err", 32'(bus.load_err), 32'd1);
        chk("blk_start_done", 32'(bus.load_done), 32'd0);
        chk_log("blk_start", rows);

        // Blocked exit cell.
        rows = std_rows;
        rows[15] = 16'hFFFF;
        start_load();
        chk("blk_exit_err_cleared", 32'(bus.load_err), 32'd0);
        for (int i = 0; i < 16; i++) send_row(rows[i]);
        wait_end("blk_exit", 16, n);
        chk("blk_exit_err", 32'(bus.load_err), 32'd1);
        chk("blk_exit_done", 32'(bus.load_done), 32'd0);

        // Gap of three cycles after row 5.
        wr_addr.delete();
        wr_data.delete();
        start_load();
        for (int i = 0; i < 6; i++) send_row(std_rows[i]);
        for (int g = 0; g < 3; g++) begin
            step();
            chk($sformatf("gap%0d_we", g), 32'(bus.mem_we), 32'd0);
        end
        for (int i = 6; i < 16; i++) send_row(std_rows[i]);
        wait_end("gap", 16, n);
        chk("gap_done", 32'(bus.load_done), 32'd1);
        chk_log("gap", std_rows);

        // Abort after row 7, restart in the same cycle din_valid is high.
        start_load();
        for (int i = 0; i < 8; i++) send_row(std_rows[i]);
        bus.load_start = 1'b1;
        bus.din_valid  = 1'b1;
        bus.din        = 16'hBEEF;
        step();
        bus.load_start = 1'b0;
        bus.din_valid  = 1'b0;
        chk("abort_we", 32'(bus.mem_we), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < 16; i++) send_row(std_rows[i]);
        wait_end("abort", 16, n);
        chk("abort_done", 32'(bus.load_done), 32'd1);
        chk_log("abort", std_rows);

        // Asynchronous reset with row 9's write pending.
        wr_addr.delete();
        wr_data.delete();
        start_load();
        for (int i = 0; i < 10; i++) send_row(std_rows[i]);
        chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
        bus.din_valid = 1'b1;
        bus.din       = 16'h0000;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk_all("post_rst", 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        bus.din_valid = 1'b0;
        chk("rst_nwrites", 32'(wr_addr.size()), 32'd9);
        wr_addr.delete();
        wr_data.delete();
        start_load();
        for (int i = 0; i < 16; i++) send_row(std_rows[i]);
        wait_end("reload", 16, n);
        chk("reload_done", 32'(bus.load_done), 32'd1);
        chk_log("reload", std_rows);

`ifdef MAZE_PARITY_EN
        // Bad parity on row 3: row still written, load ends in ERR.
        wr_addr.delete();
        wr_data.delete();
        start_load();
        for (int i = 0; i < 16; i++) begin
            bad_par = (i == 3);
            send_row(std_rows[i]);
        end
        bad_par = 1'b0;
        wait_end("parity", 16, n);
        chk("parity_err", 32'(bus.load_err), 32'd1);
        chk("parity_done", 32'(bus.load_done), 32'd0);
        chk_log("parity", std_rows);
        start_load();
        for (int i = 0; i < 16; i++) send_row(std_rows[i]);
        wait_end("parity_clr", 16, n);
        chk("parity_clr_done", 32'(bus.load_done), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maze_loader.md
MAZE_LOADER -- requirements
Module: maze_loader

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of maze rows (memory depth).
REQ-002 SHALL have parameter COLS, default 16, cells per row (word width); bit = 1 means wall, bit = 0 means open.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_start  input  1  one-cycle request to begin loading a maze.
REQ-006 SHALL have port din_valid  input  1  row word present on din.
REQ-007 SHALL have port din  input  COLS  maze row data; row 0 first.
REQ-008 SHALL have port din_ready  output  1  loader accepts a row this cycle.
REQ-009 SHALL have port mem_we  output  1  maze memory write strobe.
REQ-010 SHALL have port mem_addr  output  $clog2(ROWS)  row address for the write.
REQ-011 SHALL have port mem_wdata  output  COLS  row word to write.
REQ-012 SHALL have port busy  output  1  high in LOAD and CHECK.
REQ-013 SHALL have port load_done  output  1  maze valid; serves as the maze controller's start.
REQ-014 SHALL have port load_err  output  1  load rejected.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, CHECK, DONE and ERR.
REQ-016 SHALL transition IDLE/DONE/ERR -> LOAD on load_start, clearing the row counter, load_done and load_err.
REQ-017 SHALL drive din_ready = 1 only in LOAD; a row transfer occurs on din_valid & din_ready.
REQ-018 SHALL make each transfer drive mem_we = 1, mem_addr = row counter and mem_wdata = din in the next cycle (1-cycle latency), with at most one write per cycle.
REQ-019 SHALL increment the row counter per transfer; the transfer of row ROWS-1 moves the FSM to CHECK, with din_ready = 0 from that point.
REQ-020 SHALL have CHECK last exactly one cycle and go to DONE if start cell row0[0] == 0 and exit cell row(ROWS-1)[COLS-1] == 0, else go to ERR; both bits are captured during LOAD.
REQ-021 SHALL hold load_done = 1 in DONE and load_err = 1 in ERR until the next load_start.
REQ-022 SHALL treat load_start during LOAD or CHECK as an abort-and-restart: counter to 0, FSM stays/returns to LOAD, and no transfer is accepted that cycle.
REQ-023 SHALL give load_start priority over din_valid in the same cycle.
REQ-024 SHALL ignore din_valid outside LOAD, with no write and no state change.
REQ-025 SHALL allow din_valid gaps (din_valid low mid-load) without limit; the counter holds.
REQ-026 SHALL not wrap the counter; no transfer is possible after row ROWS-1.

Reset
REQ-027 SHALL, while rst = 0, force the FSM to IDLE, row counter 0, mem_we 0, mem_addr 0, mem_wdata 0, din_ready 0, busy 0, load_done 0 and load_err 0.
REQ-028 SHALL, on reset mid-LOAD, suppress any pending write, leave memory contents undefined, and require a new load_start to reload.

Configuration
REQ-029 SHALL use macro MAZE_PARITY_EN to select per-row parity checking.
REQ-030 SHALL, with MAZE_PARITY_EN defined, add input din_par (1 bit, even parity over din) and treat any transfer whose XOR(din, din_par) != 0 as errored.
REQ-031 SHALL, with MAZE_PARITY_EN defined, still write an errored row, set a sticky flag, and have CHECK go to ERR if the flag is set.
REQ-032 SHALL, without MAZE_PARITY_EN, have no din_par port and no parity logic; behaviour is per REQ-020.

Structure
REQ-033 SHALL place ROWS/COLS defaults and the FSM state enum in shared package maze_pkg, also used by the maze controller.
REQ-034 SHALL implement parity as sub-module row_parity (din, din_par -> par_err), instantiated only under MAZE_PARITY_EN.

Verification
REQ-035 SHALL cover normal load: load_start; 16 rows 0xFFFE, 0x0000 x14, 0x7FFF back-to-back -> 16 writes at addr 0..15, CHECK -> DONE, load_done = 1 at cycle 18 after load_start.
REQ-036 SHALL cover blocked start: row0 = 0x0001 -> ERR, load_err = 1, load_done = 0.
REQ-037 SHALL cover gaps: din_valid low 3 cycles after row 5 -> no write during the gap, counter stays 6, load completes with 16 writes total.
REQ-038 SHALL cover abort: load_start after row 7 -> next accepted row written at addr 0, exactly 16 further writes to DONE.
REQ-039 SHALL cover async reset: rst low mid-LOAD at row 9 -> all outputs 0 immediately, no write next cycle; load_start then reloads from addr 0.
REQ-040 SHALL cover parity (MAZE_PARITY_EN): bad din_par on row 3 -> row still written, FSM ends in ERR, load_err = 1.
